// File: rtl/alu_req_arbiter_pkg.sv
// Shared op encodings, FSM states and constants for the ALU request arbiter.
// Optional rsp_err output is enabled with ALU_DIV0_ERR_EN.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_NOT = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/alu_req_arbiter_operation.sv
// Combinational 4-bit ALU: zero-extended operands, 8-bit result mod 256.
// A zero divisor yields 0 here; the arbiter substitutes its own constant.
module operation
    import alu_pkg::*;
(
    input  logic [2:0] op,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] result
);

    logic [7:0] w_a8;
    logic [7:0] w_b8;

    assign w_a8 = {4'h0, a};
    assign w_b8 = {4'h0, b};

    always_comb begin
        result = 8'h00;
        unique case (op)
            OP_ADD:  result = w_a8 + w_b8;
            OP_SUB:  result = w_a8 - w_b8;
            OP_MUL:  result = w_a8 * w_b8;
            OP_DIV:  result = (b == 4'h0) ? 8'h00 : (w_a8 / w_b8);
            OP_AND:  result = w_a8 & w_b8;
            OP_OR:   result = w_a8 | w_b8;
            OP_XOR:  result = w_a8 ^ w_b8;
            OP_NOT:  result = ~w_a8;
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ valid/ready requesters.
// Define ALU_DIV0_ERR_EN to add the rsp_err divide-by-zero flag output.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int RESULT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [3*NUM_REQ-1:0] req_op,
    input  logic [4*NUM_REQ-1:0] req_a,
    input  logic [4*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [RESULT_W-1:0]  rsp_result,
`ifdef ALU_DIV0_ERR_EN
    output logic                 rsp_err,
`endif
    output logic                 busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // First requester at or after ptr, wrapping; lowest offset wins.
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr
    );
        int idx;
        rr_pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (valid[PTR_W'(idx)]) rr_pick = PTR_W'(idx);
        end
    endfunction

    state_e           r_state;
    state_e           w_state_nxt;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_owner;
    logic [2:0]       r_op;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [RESULT_W-1:0] r_result;

    logic [PTR_W-1:0] w_pick;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_accept;
    logic             w_div0;
    logic [7:0]       w_alu;

    assign w_pick    = rr_pick(req_valid, r_rr_ptr);
    assign w_ptr_nxt = (w_pick == PTR_W'(NUM_REQ - 1)) ? '0
                                                        : w_pick + PTR_W'(1);
    assign w_div0    = (r_op == OP_DIV) && (r_b == 4'h0);

    operation u_alu (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .result (w_alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready[r_owner]) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_op     <= OP_ADD;
            r_a      <= 4'h0;
            r_b      <= 4'h0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_pick;
                r_rr_ptr <= w_ptr_nxt;
                r_op     <= req_op[3*w_pick +: 3];
                r_a      <= req_a[4*w_pick +: 4];
                r_b      <= req_b[4*w_pick +: 4];
            end
            // Divide by zero never lets the raw ALU output through.
            if (r_state == EXEC) begin
                r_result <= w_div0 ? DIV0_RESULT : w_alu;
            end
        end
    end

`ifdef ALU_DIV0_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_err <= 1'b0;
        else if (r_state == EXEC) r_err <= w_div0;
    end

    assign rsp_err = r_err;
`endif

    // Reset gates the combinational grant so it reads 0 while held.
    assign req_ready  = (w_accept && !rst)
                        ? (NUM_REQ'(1) << w_pick) : '0;
    assign rsp_valid  = (r_state == RESP)
                        ? (NUM_REQ'(1) << r_owner) : '0;
    assign rsp_result = r_result;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: cycle-level reference model plus directed vectors.
// Build with ALU_DIV0_ERR_EN defined to also cover the rsp_err output.
module tb_alu_req_arbiter;

    localparam int N = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [7:0]     rsp_result;
`ifdef ALU_DIV0_ERR_EN
    logic           rsp_err;
`endif
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_req_arbiter #(.NUM_REQ(N), .RESULT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
`ifdef ALU_DIV0_ERR_EN
        .rsp_err    (rsp_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic straight from the operation table, on plain integers.
    function automatic int alu_ref(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: r = (b == 0) ? 255 : a / b;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = 255 - a;
        endcase
        return r & 255;
    endfunction

    // Model: cycles since the accepted request (0 = free, 1 = computing, 2 = responding).
    int m_age   = 0;
    int m_ptr   = 0;
    int m_owner = 0;
    int m_res   = 0;
    int m_err   = 0;

    always @(negedge clk) begin
        int pick;
        int exp_ready;
        int exp_rv;
        if (rst) begin
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_result", 32'(rsp_result), 0);
            check("rst_busy", 32'(busy), 0);
`ifdef ALU_DIV0_ERR_EN
            check("rst_rsp_err", 32'(rsp_err), 0);
`endif
            m_age = 0;
            m_ptr = 0;
        end else begin
            pick = -1;
            for (int k = N - 1; k >= 0; k--)
                if (req_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            exp_ready = (m_age == 0 && pick >= 0) ? (1 << pick) : 0;
            exp_rv    = (m_age == 2) ? (1 << m_owner) : 0;
            check("m_req_ready", 32'(req_ready), exp_ready);
            check("m_rsp_valid", 32'(rsp_valid), exp_rv);
            check("m_busy", 32'(busy), (m_age != 0) ? 1 : 0);
            if (m_age == 2) begin
                check("m_rsp_result", 32'(rsp_result), m_res);
`ifdef ALU_DIV0_ERR_EN
                check("m_rsp_err", 32'(rsp_err), m_err);
`endif
            end
            if (m_age == 0 && pick >= 0) begin
                m_owner = pick;
                m_res   = alu_ref(int'(req_op[3*pick +: 3]),
                                  int'(req_a[4*pick +: 4]),
                                  int'(req_b[4*pick +: 4]));
                m_err   = (req_op[3*pick +: 3] == 3'd3 &&
                           req_b[4*pick +: 4] == 4'd0) ? 1 : 0;
                m_ptr   = (pick + 1) % N;
                m_age   = 1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (m_age == 2 && rsp_ready[m_owner]) begin
                m_age = 0;
            end
        end
    end

    task automatic set_req(input int idx, input int op, input int a, input int b);
        req_valid[idx]     = 1'b1;
        req_op[3*idx +: 3] = 3'(op);
        req_a[4*idx +: 4]  = 4'(a);
        req_b[4*idx +: 4]  = 4'(b);
    endtask

    task automatic wait_ready(input int idx, input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = req_ready[idx];
        end
        check({name, "_accept"}, 32'(got), 1);
    endtask

    task automatic wait_rsp(input int idx, input string name, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid[idx]) begin
                got = 1'b1;
                lat = k;
            end
        end
        check({name, "_rsp_seen"}, 32'(got), 1);
    endtask

    task automatic run_op(input int idx, input int op, input int a, input int b,
                          input int exp, input bit exp_err, input string name);
        int lat;
        @(posedge clk); #1;
        set_req(idx, op, a, b);
        wait_ready(idx, name);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        wait_rsp(idx, name, lat);
        check({name, "_latency"}, 32'(lat), 2);
        check({name, "_result"}, 32'(rsp_result), 32'(exp));
`ifdef ALU_DIV0_ERR_EN
        check({name, "_err"}, 32'(rsp_err), 32'(exp_err));
`else
        if (exp_err) check({name, "_div0_ff"}, 32'(rsp_result), 32'hFF);
`endif
    endtask

    int sweep_exp [8] = '{8'h08, 8'h02, 8'h0F, 8'h01,
                          8'h01, 8'h07, 8'h06, 8'hFA};
    int fair_exp  [5] = '{0, 1, 0, 1, 0};

    initial begin
        int lat;
        int ng;
        bit seen;
        int grants [5];

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;

        // Request held during reset must not be granted.
        @(posedge clk); #1;
        set_req(0, 0, 1, 1);
        repeat (2) @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk); #1 rst = 1'b0;

        run_op(0, 2, 7, 6, 8'h2A, 1'b0, "single");

        for (int i = 0; i < 8; i++)
            run_op(i % 2, i, 5, 3, sweep_exp[i], 1'b0, $sformatf("sweep%0d", i));

        run_op(1, 3, 9, 0, 8'hFF, 1'b1, "div0");
        run_op(0, 3, 9, 2, 8'h04, 1'b0, "div_after0");

        // Backpressure: owner stalls while the other requester waits.
        @(posedge clk); #1;
        rsp_ready = 2'b10;
        set_req(0, 0, 3, 4);
        wait_ready(0, "bp");
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 6, 10, 5);
        wait_rsp(0, "bp", lat);
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'b01);
            check("bp_result", 32'(rsp_result), 32'h07);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_busy", 32'(busy), 1);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 2'b11;
        wait_ready(1, "bp_next");
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_rsp(1, "bp_next", lat);
        check("bp_next_result", 32'(rsp_result), 32'h0F);

        // Reset while the request is being computed drops it.
        @(posedge clk); #1;
        set_req(1, 2, 3, 3);
        wait_ready(1, "midrst");
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid != '0) seen = 1'b1;
        end
        check("midrst_no_rsp", 32'(seen), 0);

        // Fairness: both requesters held valid from rr_ptr = 0.
        @(posedge clk); #1;
        set_req(0, 0, 1, 1);
        set_req(1, 0, 2, 2);
        ng = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            @(negedge clk);
            if (req_ready == 2'b01) begin grants[ng] = 0; ng++; end
            else if (req_ready == 2'b10) begin grants[ng] = 1; ng++; end
        end
        @(posedge clk); #1 req_valid = '0;
        check("fair_count", 32'(ng), 5);
        for (int g = 0; g < 5; g++)
            check($sformatf("fair_grant%0d", g), 32'(grants[g]), 32'(fair_exp[g]));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_idle", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
